// File: rtl/layer_backward_if.sv
// Handshake and data bundle for the fully-connected backward pass.
// The master drives the operands and start; the slave returns the gradients.
interface layer_backward_if #(
    parameter int N = 4,
    parameter int M = 4
);
    logic                 start;
    logic [16*N-1:0]      x;
    logic [16*M*N-1:0]    w;
    logic [16*M-1:0]      dy;
    logic [16*N-1:0]      dx;
    logic [16*M*N-1:0]    dw;
    logic [16*M-1:0]      db;
    logic                 busy;
    logic                 done;

    modport master (
        output start, x, w, dy,
        input  dx, dw, db, busy, done
    );

    modport slave (
        input  start, x, w, dy,
        output dx, dw, db, busy, done
    );
endinterface

// File: rtl/layer_backward.sv
// Backward pass of a Q8.8 fully-connected layer using a single shared MAC.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  IDLE   | waiting for start; operands latched on the accepting edge
//  GRAD_W | dw[j][i] = dy[j]*x[i], one element per cycle (j outer)
//  GRAD_X | dx[i] = sum_j w[j][i]*dy[j], one MAC per cycle (i outer)
//  FINISH | raise done for one cycle, drop busy
module layer_backward #(
    parameter int N     = 4,
    parameter int M     = 4,
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             rst,
    layer_backward_if.slave  bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int JW = (M > 1) ? $clog2(M) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(N - 1);
    localparam logic [JW-1:0] J_LAST = JW'(M - 1);

    typedef enum logic [1:0] {IDLE, GRAD_W, GRAD_X, FINISH} state_t;

    state_t state, state_nxt;
    logic   busy_r, busy_nxt;
    logic   done_r, done_nxt;

    logic signed [15:0] x_r  [N];
    logic signed [15:0] w_r  [M][N];
    logic signed [15:0] dy_r [M];
    logic signed [15:0] dx_q [N];
    logic signed [15:0] dw_q [M][N];
    logic signed [15:0] db_q [M];

    logic [IW-1:0]           i_cnt;
    logic [JW-1:0]           j_cnt;
    logic signed [ACC_W-1:0] acc;

    logic                    accept, i_last, j_last;
    logic signed [15:0]      op_a, op_b;
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] prod_ext, prod_sh, acc_nxt, acc_sh;

    function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > ACC_W'(32767))
            return 16'sh7FFF;
        else if (v < ACC_W'(-32768))
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    assign accept = (state == IDLE) && bus.start;
    assign i_last = (i_cnt == I_LAST);
    assign j_last = (j_cnt == J_LAST);

    // Shared MAC: operands steered by phase, accumulator restarts at j==0.
    always_comb begin
        op_a = dy_r[j_cnt];
        op_b = x_r[i_cnt];
        if (state == GRAD_X) begin
            op_a = w_r[j_cnt][i_cnt];
            op_b = dy_r[j_cnt];
        end
        prod     = op_a * op_b;
        prod_ext = ACC_W'(prod);
        prod_sh  = prod_ext >>> 8;
        acc_nxt  = ((j_cnt == '0) ? '0 : acc) + prod_ext;
        acc_sh   = acc_nxt >>> 8;
    end

    // Next-state and registered control outputs.
    always_comb begin
        state_nxt = state;
        busy_nxt  = busy_r;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = GRAD_W;
                    busy_nxt  = 1'b1;
                end
            end
            GRAD_W: if (i_last && j_last) state_nxt = GRAD_X;
            GRAD_X: if (i_last && j_last) state_nxt = FINISH;
            FINISH: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and control register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_r <= busy_nxt;
            done_r <= done_nxt;
        end
    end

    // Operand capture, loop counters, accumulator and gradient registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_cnt <= '0;
            j_cnt <= '0;
            acc   <= '0;
            for (int i = 0; i < N; i++) begin
                x_r[i]  <= '0;
                dx_q[i] <= '0;
            end
            for (int j = 0; j < M; j++) begin
                dy_r[j] <= '0;
                db_q[j] <= '0;
                for (int i = 0; i < N; i++) begin
                    w_r[j][i]  <= '0;
                    dw_q[j][i] <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        i_cnt <= '0;
                        j_cnt <= '0;
                        for (int i = 0; i < N; i++)
                            x_r[i] <= bus.x[16*i +: 16];
                        for (int j = 0; j < M; j++) begin
                            dy_r[j] <= bus.dy[16*j +: 16];
                            db_q[j] <= bus.dy[16*j +: 16];
                            for (int i = 0; i < N; i++)
                                w_r[j][i] <= bus.w[16*(j*N+i) +: 16];
                        end
                    end
                end
                GRAD_W: begin
                    dw_q[j_cnt][i_cnt] <= sat16(prod_sh);
                    if (i_last) begin
                        i_cnt <= '0;
                        j_cnt <= j_last ? '0 : j_cnt + 1'b1;
                    end else begin
                        i_cnt <= i_cnt + 1'b1;
                    end
                end
                GRAD_X: begin
                    acc <= acc_nxt;
                    if (j_last) begin
                        dx_q[i_cnt] <= sat16(acc_sh);
                        j_cnt <= '0;
                        i_cnt <= i_last ? '0 : i_cnt + 1'b1;
                    end else begin
                        j_cnt <= j_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pack gradient arrays onto the flat bus vectors.
    always_comb begin
        bus.dx = '0;
        bus.dw = '0;
        bus.db = '0;
        for (int i = 0; i < N; i++)
            bus.dx[16*i +: 16] = dx_q[i];
        for (int j = 0; j < M; j++) begin
            bus.db[16*j +: 16] = db_q[j];
            for (int i = 0; i < N; i++)
                bus.dw[16*(j*N+i) +: 16] = dw_q[j][i];
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
endmodule

// File: tb/tb_layer_backward.sv
// Directed bench for layer_backward: a 1x1 and a 2x2 instance share clk/rst.
module tb_layer_backward;
    logic clk;
    logic rst;

    int nvec  = 0;
    int nfail = 0;
    int lat;
    bit bok;
    int cnt;
    int ndone;

    layer_backward_if #(.N(1), .M(1)) bus1 ();
    layer_backward_if #(.N(2), .M(2)) bus2 ();

    layer_backward #(.N(1), .M(1), .ACC_W(40)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    layer_backward #(.N(2), .M(2), .ACC_W(40)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit g_done(input bit sel);
        return sel ? bus2.done : bus1.done;
    endfunction

    function automatic bit g_busy(input bit sel);
        return sel ? bus2.busy : bus1.busy;
    endfunction

    // Pulse start on the selected instance and count edges until done is seen.
    // lat = -1 if done never arrives; ok = busy high before done and low with it.
    task automatic run_pass(input bit sel, output int lat_o, output bit ok_o);
        if (sel) bus2.start = 1'b1; else bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        bus2.start = 1'b0;
        ok_o  = 1'b1;
        lat_o = -1;
        if (!g_busy(sel)) ok_o = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (g_done(sel)) begin
                lat_o = c;
                if (g_busy(sel)) ok_o = 1'b0;
                break;
            end
            if (!g_busy(sel)) ok_o = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus1.start = 1'b0; bus1.x = '0; bus1.w = '0; bus1.dy = '0;
        bus2.start = 1'b0; bus2.x = '0; bus2.w = '0; bus2.dy = '0;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();

        // reset state
        chk("rst_busy1", 64'(bus1.busy), 64'd0);
        chk("rst_done1", 64'(bus1.done), 64'd0);
        chk("rst_dx1",   64'(bus1.dx),   64'd0);
        chk("rst_busy2", 64'(bus2.busy), 64'd0);
        chk("rst_dw2",   64'(bus2.dw),   64'd0);
        chk("rst_db2",   64'(bus2.db),   64'd0);

        // 1x1 nominal: 2.0, 1.0, 1.0
        bus1.x = 16'h0200; bus1.w = 16'h0100; bus1.dy = 16'h0100;
        run_pass(1'b0, lat, bok);
        chk("a_latency", 64'(lat), 64'd3);
        chk("a_busy",    64'(bok), 64'd1);
        chk("a_dw",      64'(bus1.dw), 64'h0200);
        chk("a_dx",      64'(bus1.dx), 64'h0100);
        chk("a_db",      64'(bus1.db), 64'h0100);
        tick();
        chk("a_done_pulse", 64'(bus1.done), 64'd0);

        // negative operands
        bus1.x = 16'h0180; bus1.w = 16'hFF80; bus1.dy = 16'hFF00;
        run_pass(1'b0, lat, bok);
        chk("b_latency", 64'(lat), 64'd3);
        chk("b_dw", 64'(bus1.dw), 64'hFE80);
        chk("b_dx", 64'(bus1.dx), 64'h0080);
        chk("b_db", 64'(bus1.db), 64'hFF00);

        // floor of -1/256 is -1, not 0
        bus1.x = 16'h0001; bus1.w = 16'h0100; bus1.dy = 16'hFFFF;
        run_pass(1'b0, lat, bok);
        chk("c_dw_floor", 64'(bus1.dw), 64'hFFFF);
        chk("c_dx_floor", 64'(bus1.dx), 64'hFFFF);

        // positive saturation
        bus1.x = 16'h0100; bus1.w = 16'h7FFF; bus1.dy = 16'h7FFF;
        run_pass(1'b0, lat, bok);
        chk("d_dx_satpos", 64'(bus1.dx), 64'h7FFF);
        chk("d_dw",        64'(bus1.dw), 64'h7FFF);

        // negative saturation
        bus1.w = 16'h8000; bus1.dy = 16'h7FFF;
        run_pass(1'b0, lat, bok);
        chk("e_dx_satneg", 64'(bus1.dx), 64'h8000);

        // 2x2 nominal
        bus2.x  = {16'h0200, 16'h0100};
        bus2.w  = {16'h0100, 16'h0100, 16'h0000, 16'h0100};
        bus2.dy = {16'h0200, 16'h0100};
        run_pass(1'b1, lat, bok);
        chk("f_latency", 64'(lat), 64'd9);
        chk("f_busy",    64'(bok), 64'd1);
        chk("f_dx",      64'(bus2.dx), 64'h0200_0300);
        chk("f_dw",      64'(bus2.dw), 64'h0400_0200_0200_0100);
        chk("f_db",      64'(bus2.db), 64'h0200_0100);

        // start reasserted during GRAD_X with different operands is ignored
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        ndone = 0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            if (c == 5) begin
                bus2.start = 1'b1;
                bus2.dy = {16'h0000, 16'h0000};
                bus2.x  = {16'h0000, 16'h0000};
            end
            if (c == 6) bus2.start = 1'b0;
            tick();
            if (bus2.done) begin
                ndone++;
                if (lat < 0) lat = c;
            end
        end
        chk("g_done_count", 64'(ndone), 64'd1);
        chk("g_latency",    64'(lat),   64'd9);
        chk("g_dx",         64'(bus2.dx), 64'h0200_0300);
        chk("g_dw",         64'(bus2.dw), 64'h0400_0200_0200_0100);

        // reset during GRAD_W clears everything
        bus2.x  = {16'h0200, 16'h0100};
        bus2.dy = {16'h0200, 16'h0100};
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("h_busy", 64'(bus2.busy), 64'd0);
        chk("h_done", 64'(bus2.done), 64'd0);
        chk("h_dx",   64'(bus2.dx),   64'd0);
        chk("h_dw",   64'(bus2.dw),   64'd0);
        chk("h_db",   64'(bus2.db),   64'd0);
        run_pass(1'b1, lat, bok);
        chk("h_latency", 64'(lat), 64'd9);
        chk("h_dx_after", 64'(bus2.dx), 64'h0200_0300);
        chk("h_dw_after", 64'(bus2.dw), 64'h0400_0200_0200_0100);

        // start together with reset: reset wins
        rst = 1'b1;
        bus2.start = 1'b1;
        tick();
        rst = 1'b0;
        bus2.start = 1'b0;
        tick();
        chk("i_rst_start_busy", 64'(bus2.busy), 64'd0);
        chk("i_rst_start_db",   64'(bus2.db),   64'd0);

        // start held high: next pass begins in the first IDLE cycle after FINISH
        bus1.x = 16'h0200; bus1.w = 16'h0100; bus1.dy = 16'h0100;
        bus1.start = 1'b1;
        tick();
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (bus1.done) begin
                lat = c;
                break;
            end
        end
        chk("j_first_latency", 64'(lat), 64'd3);
        tick();
        bus1.start = 1'b0;
        cnt = -1;
        for (int c = 2; c <= 20; c++) begin
            tick();
            if (bus1.done) begin
                cnt = c;
                break;
            end
        end
        chk("j_restart_gap", 64'(cnt), 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
